// File: rtl/note_arbiter.sv
// note_arbiter: eight-key debounced monophonic arbiter with last-pressed
// priority, driving a square-wave tone whose half period comes from a
// fixed C4..C5 table counted in 1 MHz strobes.
module note_arbiter #(
  parameter int DEB_COUNT = 4,
  parameter int KEYS      = 8
) (
  input  logic            clk_100M,
  input  logic            rst,
  input  logic            tick_250,
  input  logic            tick_1M,
  input  logic [KEYS-1:0] keys_raw,
  output logic [KEYS-1:0] keys_db,
  output logic            note_valid,
  output logic [2:0]      note_idx,
  output logic            tone_out
);

  localparam int CW = $clog2(DEB_COUNT + 1);

  typedef enum logic {IDLE, PLAY} state_t;

  logic [KEYS-1:0] keys_meta_reg;
  logic [KEYS-1:0] keys_s_reg;
  logic [KEYS-1:0] keys_prev_reg;
  logic [KEYS-1:0] press;
  logic [KEYS-1:0] release_k;
  state_t          state_reg, state_next;
  logic [2:0]      note_idx_reg, note_idx_next;
  logic            load;
  logic [10:0]     counter_reg;
  logic            tone_reg;

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] lowest_bit(input logic [KEYS-1:0] v);
    lowest_bit = 3'd0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Half period of each note in 1 MHz ticks.
  function automatic logic [10:0] half_period(input logic [2:0] idx);
    case (idx)
      3'd0:    half_period = 11'd1911;
      3'd1:    half_period = 11'd1703;
      3'd2:    half_period = 11'd1517;
      3'd3:    half_period = 11'd1432;
      3'd4:    half_period = 11'd1276;
      3'd5:    half_period = 11'd1136;
      3'd6:    half_period = 11'd1012;
      default: half_period = 11'd956;
    endcase
  endfunction

  // Two-flop synchronizer for the raw key pins.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      keys_meta_reg <= '0;
      keys_s_reg    <= '0;
    end else begin
      keys_meta_reg <= keys_raw;
      keys_s_reg    <= keys_meta_reg;
    end
  end

  // One debouncer per key; a state change is accepted after DEB_COUNT
  // consecutive disagreeing 250 Hz samples, any agreement restarts the count.
  generate
    for (genvar gi = 0; gi < KEYS; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic          db_bit_reg;

      // Per-key debounce counter and accepted state.
      always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else if (tick_250) begin
          if (keys_s_reg[gi] != db_bit_reg) begin
            if (cnt_reg == CW'(DEB_COUNT - 1)) begin
              db_bit_reg <= ~db_bit_reg;
              cnt_reg    <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign keys_db[gi] = db_bit_reg;
    end
  endgenerate

  // Previous debounced state for edge detection.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) keys_prev_reg <= '0;
    else     keys_prev_reg <= keys_db;
  end

  assign press     = keys_db & ~keys_prev_reg;
  assign release_k = ~keys_db & keys_prev_reg;

  // Arbiter state and selected note register.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      note_idx_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      note_idx_reg <= note_idx_next;
    end
  end

  // Next-state logic: a new press always wins, losing the sounding key
  // falls back to the lowest key still held.
  always_comb begin
    state_next    = state_reg;
    note_idx_next = note_idx_reg;
    load          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|press) begin
          note_idx_next = lowest_bit(press);
          load          = 1'b1;
          state_next    = PLAY;
        end
      end
      default: begin
        if (|press) begin
          note_idx_next = lowest_bit(press);
          load          = 1'b1;
        end else if (release_k[note_idx_reg]) begin
          if (|keys_db) begin
            note_idx_next = lowest_bit(keys_db);
            load          = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  // Tone divider; a load restarts the waveform low and swallows a
  // coincident 1 MHz tick.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      counter_reg <= 11'd0;
      tone_reg    <= 1'b0;
    end else if (load) begin
      counter_reg <= half_period(note_idx_next) - 11'd1;
      tone_reg    <= 1'b0;
    end else if (state_next == IDLE) begin
      tone_reg <= 1'b0;
    end else if (tick_1M) begin
      if (counter_reg == 11'd0) begin
        tone_reg    <= ~tone_reg;
        counter_reg <= half_period(note_idx_reg) - 11'd1;
      end else begin
        counter_reg <= counter_reg - 11'd1;
      end
    end
  end

  assign note_valid = (state_reg == PLAY);
  assign note_idx   = note_idx_reg;
  assign tone_out   = tone_reg;

endmodule
